// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared defaults, scoreboard op encoding and popcount helper
package reg_file_pkg;
  localparam int W_DEF = 8;
  localparam int A_DEF = 2;
  localparam int NR_DEF = 2;
  typedef enum logic [1:0] {SB_HOLD, SB_SET, SB_CLR, SB_FLUSH} sb_op_e;
  function automatic int popcount(input logic [63:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) n += int'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: decode-side bus of the register file and scoreboard
interface reg_file_sb_if #(parameter int W = 8, parameter int A = 2, parameter int NR = 2);
  logic                   i_write_en;
  logic [A-1:0]           i_waddr;
  logic [W-1:0]           i_data_in;
  logic [NR-1:0][A-1:0]   i_raddr;
  logic [NR-1:0][W-1:0]   o_data_out;
  logic [NR-1:0]          o_rd_busy;
  logic                   i_issue;
  logic [A-1:0]           i_issue_addr;
  logic                   o_issue_ok;
  logic                   i_flush;
  logic [2**A-1:0]        o_busy;
  logic [A:0]             o_pending;
  modport master (
    output i_write_en, i_waddr, i_data_in, i_raddr, i_issue, i_issue_addr, i_flush,
    input  o_data_out, o_rd_busy, o_issue_ok, o_busy, o_pending
  );
  modport slave (
    input  i_write_en, i_waddr, i_data_in, i_raddr, i_issue, i_issue_addr, i_flush,
    output o_data_out, o_rd_busy, o_issue_ok, o_busy, o_pending
  );
endinterface

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits, pending count and issue acceptance
module rf_scoreboard
  import reg_file_pkg::*;
#(
  parameter int A = A_DEF,
  parameter int ZERO_REG = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_write_en,
  input  logic [A-1:0]    i_waddr,
  input  logic            i_issue,
  input  logic [A-1:0]    i_issue_addr,
  input  logic            i_flush,
  output logic            o_issue_ok,
  output logic [2**A-1:0] o_busy,
  output logic [A:0]      o_pending
);
  localparam int D = 2**A;
  logic [D-1:0] r_busy;
  logic [A:0]   r_pending;
  logic [D-1:0] w_busy_nxt;
  sb_op_e       w_op [D];
  // a set outranks a same-cycle write clear, flush outranks everything
  always_comb begin
    o_issue_ok = i_issue & ~r_busy[i_issue_addr] & ~i_flush & ~((ZERO_REG != 0) & (i_issue_addr == '0));
    w_busy_nxt = r_busy;
    for (int b = 0; b < D; b++) begin
      w_op[b] = i_flush ? SB_FLUSH :
                (o_issue_ok && i_issue_addr == A'(b)) ? SB_SET :
                (i_write_en && i_waddr == A'(b)) ? SB_CLR : SB_HOLD;
      w_busy_nxt[b] = (w_op[b] == SB_SET) | ((w_op[b] == SB_HOLD) & r_busy[b]);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy    <= '0;
      r_pending <= '0;
    end else begin
      r_busy    <= w_busy_nxt;
      r_pending <= (A+1)'(popcount(64'(w_busy_nxt)));
    end
  end
  assign o_busy    = r_busy;
  assign o_pending = r_pending;
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-port register file with write bypass and busy scoreboard
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int A = A_DEF,
  parameter int NR = NR_DEF,
  parameter int ZERO_REG = 0,
  parameter int BYPASS = 1
) (
  input logic         clk,
  input logic         rst_n,
  reg_file_sb_if.slave bus
);
  localparam int D = 2**A;
  logic [W-1:0]         r_mem [D];
  logic [D-1:0]         w_busy;
  logic [NR-1:0][W-1:0] w_dout;
  logic [NR-1:0]        w_rd_busy;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) r_mem[i] <= '0;
    end else if (bus.i_write_en && !((ZERO_REG != 0) && bus.i_waddr == '0)) begin
      r_mem[bus.i_waddr] <= bus.i_data_in;
    end
  end
  rf_scoreboard #(.A(A), .ZERO_REG(ZERO_REG)) u_sb (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_write_en   (bus.i_write_en),
    .i_waddr      (bus.i_waddr),
    .i_issue      (bus.i_issue),
    .i_issue_addr (bus.i_issue_addr),
    .i_flush      (bus.i_flush),
    .o_issue_ok   (bus.o_issue_ok),
    .o_busy       (w_busy),
    .o_pending    (bus.o_pending)
  );
  for (genvar p = 0; p < NR; p++) begin : g_rd
    logic w_zero, w_byp;
    assign w_zero       = (ZERO_REG != 0) && bus.i_raddr[p] == '0;
    // a forwarded write also retires the producer, so the port sees it free
    assign w_byp        = (BYPASS != 0) && bus.i_write_en && bus.i_waddr == bus.i_raddr[p] && !w_zero;
    assign w_dout[p]    = w_zero ? '0 : w_byp ? bus.i_data_in : r_mem[bus.i_raddr[p]];
    assign w_rd_busy[p] = !w_byp && w_busy[bus.i_raddr[p]];
  end
  assign bus.o_data_out = w_dout;
  assign bus.o_rd_busy  = w_rd_busy;
  assign bus.o_busy     = w_busy;
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: two configurations (A=2/NR=2/bypass, A=4/NR=3/zero-reg/no-bypass)
// checked against a behavioural register-file model every cycle
module tb_reg_file_sb;
  logic clk = 0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  always #5 clk = ~clk;
  logic       s_we [2];
  logic [3:0] s_waddr [2];
  logic [7:0] s_din [2];
  logic [3:0] s_raddr [2][3];
  logic       s_issue [2];
  logic [3:0] s_iaddr [2];
  logic       s_flush [2];
  logic [7:0]  o_dout [2][3];
  logic        o_rdbusy [2][3];
  logic        o_ok [2];
  logic [15:0] o_busy [2];
  logic [4:0]  o_pend [2];
  reg_file_sb_if #(.W(8), .A(2), .NR(2)) bus_a ();
  reg_file_sb_if #(.W(8), .A(4), .NR(3)) bus_b ();
  reg_file_sb #(.W(8), .A(2), .NR(2), .ZERO_REG(0), .BYPASS(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  reg_file_sb #(.W(8), .A(4), .NR(3), .ZERO_REG(1), .BYPASS(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  assign bus_a.i_write_en   = s_we[0];
  assign bus_a.i_waddr      = s_waddr[0][1:0];
  assign bus_a.i_data_in    = s_din[0];
  assign bus_a.i_raddr      = {s_raddr[0][1][1:0], s_raddr[0][0][1:0]};
  assign bus_a.i_issue      = s_issue[0];
  assign bus_a.i_issue_addr = s_iaddr[0][1:0];
  assign bus_a.i_flush      = s_flush[0];
  assign bus_b.i_write_en   = s_we[1];
  assign bus_b.i_waddr      = s_waddr[1];
  assign bus_b.i_data_in    = s_din[1];
  assign bus_b.i_raddr      = {s_raddr[1][2], s_raddr[1][1], s_raddr[1][0]};
  assign bus_b.i_issue      = s_issue[1];
  assign bus_b.i_issue_addr = s_iaddr[1];
  assign bus_b.i_flush      = s_flush[1];
  assign o_dout[0][0] = bus_a.o_data_out[0];
  assign o_dout[0][1] = bus_a.o_data_out[1];
  assign o_dout[0][2] = 8'h00;
  assign o_dout[1][0] = bus_b.o_data_out[0];
  assign o_dout[1][1] = bus_b.o_data_out[1];
  assign o_dout[1][2] = bus_b.o_data_out[2];
  assign o_rdbusy[0][0] = bus_a.o_rd_busy[0];
  assign o_rdbusy[0][1] = bus_a.o_rd_busy[1];
  assign o_rdbusy[0][2] = 1'b0;
  assign o_rdbusy[1][0] = bus_b.o_rd_busy[0];
  assign o_rdbusy[1][1] = bus_b.o_rd_busy[1];
  assign o_rdbusy[1][2] = bus_b.o_rd_busy[2];
  assign o_ok[0]   = bus_a.o_issue_ok;
  assign o_ok[1]   = bus_b.o_issue_ok;
  assign o_busy[0] = {12'h000, bus_a.o_busy};
  assign o_busy[1] = bus_b.o_busy;
  assign o_pend[0] = {2'b00, bus_a.o_pending};
  assign o_pend[1] = bus_b.o_pending;

  // model: k=0 is 4 regs / bypass, k=1 is 16 regs / zero reg / no bypass
  logic [7:0] m_reg [2][16];
  bit         m_busy [2][16];
  function automatic int msk(int k); return k == 1 ? 15 : 3; endfunction
  function automatic int nrp(int k); return k == 1 ? 3 : 2; endfunction
  function automatic bit zr(int k); return k == 1; endfunction
  function automatic bit by(int k); return k == 0; endfunction
  function automatic int wa(int k); return int'(s_waddr[k]) & msk(k); endfunction
  function automatic int ia(int k); return int'(s_iaddr[k]) & msk(k); endfunction
  function automatic int ra(int k, int p); return int'(s_raddr[k][p]) & msk(k); endfunction
  function automatic bit fwd(int k, int p);
    return by(k) && s_we[k] && wa(k) == ra(k, p) && !(zr(k) && ra(k, p) == 0);
  endfunction
  function automatic logic [7:0] exp_dout(int k, int p);
    if (zr(k) && ra(k, p) == 0) return 8'h00;
    if (fwd(k, p)) return s_din[k];
    return m_reg[k][ra(k, p)];
  endfunction
  function automatic bit exp_rdbusy(int k, int p);
    return !fwd(k, p) && m_busy[k][ra(k, p)];
  endfunction
  function automatic bit exp_ok(int k);
    return s_issue[k] && !m_busy[k][ia(k)] && !s_flush[k] && !(zr(k) && ia(k) == 0);
  endfunction
  function automatic logic [15:0] exp_busy(int k);
    logic [15:0] v = '0;
    for (int i = 0; i < 16; i++) v[i] = m_busy[k][i];
    return v;
  endfunction
  function automatic logic [4:0] exp_pend(int k);
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(m_busy[k][i]);
    return 5'(n);
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 16; i++) begin
          m_reg[k][i]  <= 8'h00;
          m_busy[k][i] <= 1'b0;
        end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (s_we[k] && !(zr(k) && wa(k) == 0)) m_reg[k][wa(k)] <= s_din[k];
        for (int i = 0; i < 16; i++)
          m_busy[k][i] <= s_flush[k] ? 1'b0 : (exp_ok(k) && ia(k) == i) ? 1'b1 :
                          (s_we[k] && wa(k) == i) ? 1'b0 : m_busy[k][i];
      end
    end
  end

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < nrp(k); p++) begin
        chk($sformatf("dout[%0d][%0d]", k, p), 16'(o_dout[k][p]), 16'(exp_dout(k, p)));
        chk($sformatf("rdbusy[%0d][%0d]", k, p), 16'(o_rdbusy[k][p]), 16'(exp_rdbusy(k, p)));
      end
      chk($sformatf("issue_ok[%0d]", k), 16'(o_ok[k]), 16'(exp_ok(k)));
      chk($sformatf("busy[%0d]", k), o_busy[k], exp_busy(k));
      chk($sformatf("pending[%0d]", k), 16'(o_pend[k]), 16'(exp_pend(k)));
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  initial begin
    rst_n = 0;
    for (int k = 0; k < 2; k++) begin
      s_we[k] = 0; s_waddr[k] = 0; s_din[k] = 0; s_issue[k] = 0; s_iaddr[k] = 0; s_flush[k] = 0;
      for (int p = 0; p < 3; p++) s_raddr[k][p] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", o_busy[0], 16'h0000);
    chk("rst_pend", 16'(o_pend[0]), 16'h0000);
    chk("rst_dout", 16'(o_dout[0][0]), 16'h0000);
    rst_n = 1;
    tick(); s_we[0] = 1; s_waddr[0] = 2; s_din[0] = 8'hA5; s_raddr[0][0] = 2;
    #3 chk("byp_a5", 16'(o_dout[0][0]), 16'h00A5);
    chk("byp_rdbusy", 16'(o_rdbusy[0][0]), 16'h0000);
    tick(); s_we[0] = 0;
    #3 chk("rd_a5", 16'(o_dout[0][0]), 16'h00A5);
    tick(); s_issue[0] = 1; s_iaddr[0] = 3;
    #3 chk("iss3_ok", 16'(o_ok[0]), 16'h0001);
    tick(); s_raddr[0][1] = 3;
    #3 chk("iss3_busy", o_busy[0], 16'h0008);
    chk("iss3_pend", 16'(o_pend[0]), 16'h0001);
    chk("iss3_rdbusy", 16'(o_rdbusy[0][1]), 16'h0001);
    chk("waw_ok", 16'(o_ok[0]), 16'h0000);
    chk("model_busy", exp_busy(0), 16'h0008);
    tick(); s_issue[0] = 0; s_we[0] = 1; s_waddr[0] = 3; s_din[0] = 8'h3C;
    #3 chk("wr3_byp", 16'(o_dout[0][1]), 16'h003C);
    chk("wr3_rdbusy", 16'(o_rdbusy[0][1]), 16'h0000);
    tick(); s_we[0] = 0;
    #3 chk("wr3_clr", o_busy[0], 16'h0000);
    chk("wr3_rd", 16'(o_dout[0][1]), 16'h003C);
    tick(); s_issue[0] = 1; s_iaddr[0] = 1; s_we[0] = 1; s_waddr[0] = 1; s_din[0] = 8'h11;
    #3 chk("setwin_ok", 16'(o_ok[0]), 16'h0001);
    tick(); s_issue[0] = 0; s_we[0] = 0; s_raddr[0][0] = 1;
    #3 chk("setwin_busy", o_busy[0], 16'h0002);
    chk("setwin_data", 16'(o_dout[0][0]), 16'h0011);
    tick(); s_issue[0] = 1; s_iaddr[0] = 2;
    tick(); s_issue[0] = 0; s_raddr[0][0] = 2; s_raddr[0][1] = 3;
    #1 chk("pre_rst_busy", o_busy[0], 16'h0006);
    chk("pre_rst_pend", 16'(o_pend[0]), 16'h0002);
    chk("model_pend", 16'(exp_pend(0)), 16'h0002);
    chk("pre_rst_d0", 16'(o_dout[0][0]), 16'h00A5);
    #1 rst_n = 0;
    #1 chk("async_d0", 16'(o_dout[0][0]), 16'h0000);
    chk("async_d1", 16'(o_dout[0][1]), 16'h0000);
    chk("async_busy", o_busy[0], 16'h0000);
    chk("async_pend", 16'(o_pend[0]), 16'h0000);
    tick(); rst_n = 1;
    tick(); s_issue[0] = 1; s_iaddr[0] = 1; s_we[0] = 1; s_waddr[0] = 1; s_din[0] = 8'h77;
    tick(); s_we[0] = 0; s_iaddr[0] = 2;
    tick(); s_iaddr[0] = 3;
    tick(); s_issue[0] = 0;
    #3 chk("b1110", o_busy[0], 16'h000E);
    chk("b1110_pend", 16'(o_pend[0]), 16'h0003);
    tick(); s_flush[0] = 1; s_issue[0] = 1; s_iaddr[0] = 0;
    #3 chk("flush_ok", 16'(o_ok[0]), 16'h0000);
    tick(); s_flush[0] = 0; s_issue[0] = 0; s_raddr[0][0] = 1;
    #3 chk("flush_busy", o_busy[0], 16'h0000);
    chk("flush_pend", 16'(o_pend[0]), 16'h0000);
    chk("flush_data", 16'(o_dout[0][0]), 16'h0077);
    tick(); s_we[1] = 1; s_waddr[1] = 0; s_din[1] = 8'hFF; s_raddr[1][0] = 0;
    #3 chk("z_byp", 16'(o_dout[1][0]), 16'h0000);
    tick(); s_we[1] = 0; s_issue[1] = 1; s_iaddr[1] = 0;
    #3 chk("z_rd", 16'(o_dout[1][0]), 16'h0000);
    chk("z_ok", 16'(o_ok[1]), 16'h0000);
    tick(); s_issue[1] = 0; s_we[1] = 1; s_waddr[1] = 5; s_din[1] = 8'h5A; s_raddr[1][1] = 5;
    #3 chk("z_busy", o_busy[1], 16'h0000);
    chk("nobyp_old", 16'(o_dout[1][1]), 16'h0000);
    tick(); s_we[1] = 0;
    #3 chk("nobyp_new", 16'(o_dout[1][1]), 16'h005A);
    for (int c = 0; c < 600; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        s_we[k]    = 1'($urandom % 2);
        s_waddr[k] = 4'($urandom & msk(k));
        s_din[k]   = 8'($urandom);
        for (int p = 0; p < 3; p++) s_raddr[k][p] = ($urandom % 2 == 1) ? s_waddr[k] : 4'($urandom & msk(k));
        s_issue[k] = 1'($urandom % 2);
        s_iaddr[k] = ($urandom % 3 == 0) ? s_waddr[k] : 4'($urandom & msk(k));
        s_flush[k] = ($urandom % 16 == 0);
      end
      if (c == 300) #2 rst_n = 0;
      if (c == 302) rst_n = 1;
    end
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
